// File: rtl/mult_seq_64_if.sv
// rtl/mult_seq_64_if.sv - start/operand/result bundle for the sequential 32x32 multiplier
//
// Signals:
//   ctrl_MULT        start request, sampled on the rising clock edge
//   ctrl_signed      1 = two's-complement operands, sampled with ctrl_MULT
//   ctrl_cancel      synchronous abort of an operation in flight
//   data_operandA    32-bit multiplicand
//   data_operandB    32-bit multiplier
//   data_writeReg    64-bit product feeding the downstream product register
//   ctrl_writeEnable one-cycle write strobe for the downstream register
//   busy             high while an operation is in flight
// master drives the request side; slave is the multiplier.
interface mult_seq_64_if;
  logic        ctrl_MULT;
  logic        ctrl_signed;
  logic        ctrl_cancel;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [63:0] data_writeReg;
  logic        ctrl_writeEnable;
  logic        busy;

  modport master (
    output ctrl_MULT, ctrl_signed, ctrl_cancel, data_operandA, data_operandB,
    input  data_writeReg, ctrl_writeEnable, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_signed, ctrl_cancel, data_operandA, data_operandB,
    output data_writeReg, ctrl_writeEnable, busy
  );
endinterface

// File: rtl/mult_seq_64.sv
// rtl/mult_seq_64.sv - 33-cycle sequential 32x32 -> 64 multiplier, signed or unsigned
//
// Ports:
//   clock       single clock, rising edge
//   ctrl_reset  asynchronous active-low reset
//   bus         mult_seq_64_if.slave (start, operands, cancel, product, strobe, busy)
//
// Sign-magnitude shift-add: operand magnitudes are latched at start, 32 unsigned
// shift-add steps build the magnitude product, and the sign is applied on the
// last step when the result register is loaded.
module mult_seq_64 (
  input  logic          clock,
  input  logic          ctrl_reset,
  mult_seq_64_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_next;
  logic        start;
  logic        write_enable;
  logic        busy_int;

  logic [5:0]  count;
  logic [31:0] mcand;
  logic [63:0] acc;      // {partial sum, remaining multiplier bits}
  logic        neg;
  logic [63:0] product;

  logic [31:0] a_mag, b_mag;
  logic [32:0] step_sum;
  logic [63:0] acc_next;
  logic        last_step;

  // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
  assign a_mag = (bus.ctrl_signed && bus.data_operandA[31]) ? -bus.data_operandA : bus.data_operandA;
  assign b_mag = (bus.ctrl_signed && bus.data_operandB[31]) ? -bus.data_operandB : bus.data_operandB;

  assign step_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
  assign acc_next  = {step_sum, acc[31:1]};
  assign last_step = (count == 6'd31);

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    start        = 1'b0;
    write_enable = 1'b0;
    busy_int     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ctrl_MULT && !bus.ctrl_cancel) begin
          state_next = RUN;
          start      = 1'b1;
        end
      end
      RUN: begin
        busy_int = 1'b1;
        if (bus.ctrl_cancel) begin
          state_next = IDLE;
        end else if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // The strobe is already out this cycle; cancel only suppresses a new start.
        busy_int     = 1'b1;
        write_enable = 1'b1;
        if (bus.ctrl_MULT && !bus.ctrl_cancel) begin
          state_next = RUN;
          start      = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      count   <= 6'd0;
      mcand   <= 32'd0;
      acc     <= 64'd0;
      neg     <= 1'b0;
      product <= 64'd0;
    end else if (start) begin
      count <= 6'd0;
      mcand <= a_mag;
      acc   <= {32'd0, b_mag};
      neg   <= bus.ctrl_signed & (bus.data_operandA[31] ^ bus.data_operandB[31]);
    end else if (state == RUN && !bus.ctrl_cancel) begin
      acc   <= acc_next;
      count <= count + 6'd1;
      // Result register only changes on the step that enters DONE.
      if (last_step) begin
        product <= neg ? -acc_next : acc_next;
      end
    end
  end

  assign bus.data_writeReg    = product;
  assign bus.ctrl_writeEnable = write_enable;
  assign bus.busy             = busy_int;

endmodule

// File: tb/tb_mult_seq_64.sv
// tb/tb_mult_seq_64.sv - scoreboard bench for mult_seq_64
module tb_mult_seq_64;

  logic clock = 1'b0;
  logic ctrl_reset = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  mult_seq_64_if bus();

  mult_seq_64 dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] p;
    int          at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] hold_exp = 64'd0;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint          sa, sbv;
    longint unsigned ua, ub;
    if (s) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      return 64'(sa * sbv);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe, otherwise checks the result holds.
  always @(negedge clock) begin
    if (!ctrl_reset) begin
      chk("reset_we", 64'(bus.ctrl_writeEnable), 64'd0);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_data", bus.data_writeReg, 64'd0);
      hold_exp = 64'd0;
    end else if (bus.ctrl_writeEnable) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got data 0x%0h expected no strobe at cycle %0d", bus.data_writeReg, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("product", bus.data_writeReg, mon_e.p);
        chk("pulse_cycle", 64'(cyc), 64'(mon_e.at));
        hold_exp = mon_e.p;
      end
    end else begin
      chk("hold", bus.data_writeReg, hold_exp);
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, output int d);
    exp_t e;
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_signed   = s;
    d    = cyc;
    e.p  = model(a, b, s);
    e.at = cyc + 33;
    sb.push_back(e);
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    bus.ctrl_signed   = 1'($urandom);
  endtask

  task automatic junk(input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_signed   = 1'($urandom);
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic s);
    int d;
    issue(a, b, s, d);
    wait_cyc(d + 34);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int d, d2, k, gap, w;
    logic exp_t_dummy;
    exp_t_dummy = 1'b0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_signed   = 1'b0;
    bus.ctrl_cancel   = 1'b0;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;

    repeat (2) @(negedge clock);
    #1 ctrl_reset = 1'b1;
    @(negedge clock);

    // 3 x 5: busy through RUN and DONE, low afterwards
    issue(32'd3, 32'd5, 1'b0, d);
    for (int i = 1; i <= 33; i++) begin
      wait_cyc(d + i);
      chk("busy_active", 64'(bus.busy), 64'd1);
    end
    wait_cyc(d + 34);
    chk("busy_after", 64'(bus.busy), 64'd0);

    run_one(32'hFFFF_FFF9, 32'd6, 1'b1);
    run_one(32'hFFFF_FFF9, 32'd6, 1'b0);
    run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_one(32'h8000_0000, 32'h8000_0000, 1'b1);
    run_one(32'd0, 32'd0, 1'b1);

    // ignored start in RUN, then back-to-back start in DONE
    issue(32'd7, 32'd9, 1'b0, d);
    wait_cyc(d + 10);
    junk(32'd2, 32'd2);
    wait_cyc(d + 33);
    issue(32'd4, 32'd4, 1'b0, d2);
    wait_cyc(d2 + 34);

    // cancel mid-RUN: no strobe, result held
    issue(32'd7, 32'd9, 1'b0, d);
    wait_cyc(d + 12);
    bus.ctrl_cancel = 1'b1;
    @(negedge clock);
    bus.ctrl_cancel = 1'b0;
    void'(sb.pop_back());
    chk("busy_cancel_run", 64'(bus.busy), 64'd0);
    wait_cyc(d + 40);

    // cancel together with start in DONE: strobe completes, no new op
    issue(32'd5, 32'hFFFF_FFFA, 1'b1, d);
    wait_cyc(d + 33);
    bus.ctrl_cancel = 1'b1;
    junk(32'd1, 32'd1);
    bus.ctrl_cancel = 1'b0;
    chk("busy_cancel_done", 64'(bus.busy), 64'd0);

    // cancel together with start in IDLE
    bus.ctrl_cancel = 1'b1;
    junk(32'd3, 32'd3);
    bus.ctrl_cancel = 1'b0;
    chk("busy_cancel_idle", 64'(bus.busy), 64'd0);
    wait_cyc(cyc + 3);

    // asynchronous reset mid-RUN, then start on the first edge after release
    issue(32'd7, 32'd9, 1'b0, d);
    wait_cyc(d + 20);
    #1 ctrl_reset = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("async_reset_we", 64'(bus.ctrl_writeEnable), 64'd0);
    chk("async_reset_busy", 64'(bus.busy), 64'd0);
    chk("async_reset_data", bus.data_writeReg, 64'd0);
    @(negedge clock);
    #1 ctrl_reset = 1'b1;
    issue(32'd2, 32'd3, 1'b0, d);
    wait_cyc(d + 34);

    // randomized operations with stray starts and back-to-back restarts
    for (int n = 0; n < 25; n++) begin
      issue(pick(), pick(), 1'($urandom), d);
      if ($urandom % 2 == 1) begin
        k = int'($urandom_range(31, 2));
        wait_cyc(d + k);
        junk($urandom, $urandom);
      end
      gap = int'($urandom_range(2, 0));
      wait_cyc(d + 33 + gap);
    end

    w = 0;
    while (sb.size() > 0 && w < 100) begin
      @(negedge clock);
      w++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending strobes expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish by time 200000");
    $fatal(1);
  end

endmodule
